// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit data register between N_REQ
// requesters, with optional burst locking bounded by MAX_HOLD writes.
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   req, lock   : per-requester write request and burst-lock request
//   d_in        : packed write data, requester i at [i*WIDTH +: WIDTH]
//   q, q_valid  : shared register contents, high once any write happened
//   ack         : one-hot, the cycle after q captured requester i
//   gnt         : one-hot, while requester i holds a burst lock
//   owner       : index of the last requester written into q
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [N_REQ*WIDTH-1:0]   d_in,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]     owner_q, owner_d;

    logic [WIDTH-1:0]  data [N_REQ];
    logic [N_REQ-1:0]  eff;
    logic [PW-1:0]     w;
    logic [PW-1:0]     idx;
    logic              found;
    logic              wr;
    int                sum;

    for (genvar i = 0; i < N_REQ; i++) begin : g_data
        assign data[i] = d_in[i*WIDTH +: WIDTH];
    end

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (int'(i) == N_REQ - 1) return '0;
        return i + PW'(1);
    endfunction

    // A requester is masked while its ack is high so a single
    // request/ack handshake produces exactly one write.
    assign eff = req & ~ack_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        ack_d     = '0;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        w         = owner_q;
        idx       = '0;
        sum       = 0;
        found     = 1'b0;
        wr        = 1'b0;

        unique case (state_q)
            IDLE: begin
                for (int k = 0; k < N_REQ; k++) begin
                    sum = int'(ptr_q) + k;
                    if (sum >= N_REQ) sum = sum - N_REQ;
                    idx = PW'(sum);
                    if (!found && eff[idx]) begin
                        found = 1'b1;
                        w     = idx;
                    end
                end
                if (found) begin
                    wr = 1'b1;
                    if (lock[w] && MAX_HOLD > 1) begin
                        state_d = OWN;
                        gnt_d   = N_REQ'(1) << w;
                        hold_d  = HW'(1);
                    end else begin
                        ptr_d = next_idx(w);
                    end
                end
            end
            OWN: begin
                w = owner_q;
                if (!req[w]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_idx(w);
                end else begin
                    wr     = 1'b1;
                    hold_d = hold_q + HW'(1);
                    // Dropping lock or reaching the hold limit ends the
                    // burst after this write.
                    if (!lock[w] || hold_d == HW'(MAX_HOLD)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        ptr_d   = next_idx(w);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            q_d       = data[w];
            ack_d     = N_REQ'(1) << w;
            owner_d   = w;
            q_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ack_q     <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ack_q     <= ack_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign ack     = ack_q;
    assign gnt     = gnt_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed testbench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_HOLD=4).
// Inputs change #1 after a rising edge; outputs are checked at that point.
module tb_shared_reg_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] d_in;
    logic [7:0]  q;
    logic        q_valid;
    logic [3:0]  ack;
    logic [3:0]  gnt;
    logic [1:0]  owner;

    int n_chk;
    int n_fail;

    shared_reg_arbiter #(
        .N_REQ(4),
        .WIDTH(8),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .lock(lock),
        .d_in(d_in),
        .q(q),
        .q_valid(q_valid),
        .ack(ack),
        .gnt(gnt),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [7:0] v);
        d_in[i*8 +: 8] = v;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req    = '0;
        lock   = '0;
        d_in   = '0;

        // 1: reset and idle
        step();
        step();
        chk("rst_q", q, 8'h00);
        chk("rst_qv", q_valid, 1'b0);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 2'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ack", ack, 4'b0000);
        chk("idle_qv", q_valid, 1'b0);

        // 2: single write from requester 2
        set_d(2, 8'hA5);
        req = 4'b0100;
        step();
        chk("w2_q", q, 8'hA5);
        chk("w2_ack", ack, 4'b0100);
        chk("w2_owner", owner, 2'd2);
        chk("w2_qv", q_valid, 1'b1);
        req = 4'b0000;
        step();
        chk("w2_ack_once", ack, 4'b0000);
        chk("w2_q_hold", q, 8'hA5);

        // async reset mid-cycle clears outputs before next edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_qv", q_valid, 1'b0);
        chk("arst_owner", owner, 2'd0);
        #1 rst_n = 1'b1;

        // 3: round robin, all requesting
        d_in = 32'h13121110;
        req  = 4'b1111;
        step();
        chk("rr0_ack", ack, 4'b0001);
        chk("rr0_q", q, 8'h10);
        step();
        chk("rr1_ack", ack, 4'b0010);
        chk("rr1_q", q, 8'h11);
        step();
        chk("rr2_ack", ack, 4'b0100);
        chk("rr2_q", q, 8'h12);
        step();
        chk("rr3_ack", ack, 4'b1000);
        chk("rr3_q", q, 8'h13);
        chk("rr3_owner", owner, 2'd3);
        step();
        chk("rr4_ack", ack, 4'b0001);
        chk("rr4_q", q, 8'h10);
        req = 4'b0000;
        step();
        chk("rr_stop_ack", ack, 4'b0000);

        // 4: burst with lock by requester 1, requester 3 waiting
        set_d(1, 8'h01);
        set_d(3, 8'h33);
        req  = 4'b1010;
        lock = 4'b0010;
        step();
        chk("b0_gnt", gnt, 4'b0010);
        chk("b0_ack", ack, 4'b0010);
        chk("b0_q", q, 8'h01);
        set_d(1, 8'h02);
        step();
        chk("b1_gnt", gnt, 4'b0010);
        chk("b1_ack", ack, 4'b0010);
        chk("b1_q", q, 8'h02);
        set_d(1, 8'h03);
        step();
        chk("b2_gnt", gnt, 4'b0010);
        chk("b2_ack", ack, 4'b0010);
        chk("b2_q", q, 8'h03);
        req  = 4'b1000;
        lock = 4'b0000;
        step();
        chk("brel_ack", ack, 4'b0000);
        chk("brel_gnt", gnt, 4'b0000);
        chk("brel_q", q, 8'h03);
        step();
        chk("b3_ack", ack, 4'b1000);
        chk("b3_q", q, 8'h33);
        req = 4'b0000;
        step();
        chk("b3_done", ack, 4'b0000);

        // 5: MAX_HOLD limit; requester 0 locked, requester 2 waiting
        set_d(0, 8'hA0);
        set_d(2, 8'hC2);
        req  = 4'b0101;
        lock = 4'b0001;
        step();
        chk("h1_ack", ack, 4'b0001);
        chk("h1_gnt", gnt, 4'b0001);
        step();
        chk("h2_ack", ack, 4'b0001);
        chk("h2_gnt", gnt, 4'b0001);
        step();
        chk("h3_ack", ack, 4'b0001);
        chk("h3_gnt", gnt, 4'b0001);
        step();
        chk("h4_ack", ack, 4'b0001);
        chk("h4_gnt", gnt, 4'b0000);
        step();
        chk("h5_ack", ack, 4'b0100);
        chk("h5_q", q, 8'hC2);
        chk("h5_gnt", gnt, 4'b0000);
        step();
        chk("h6_ack", ack, 4'b0001);
        chk("h6_gnt", gnt, 4'b0001);
        chk("h6_q", q, 8'hA0);
        req  = 4'b0000;
        lock = 4'b0000;
        step();
        chk("h7_ack", ack, 4'b0000);
        chk("h7_gnt", gnt, 4'b0000);

        // 6a: lock dropped with req high gives one final write
        set_d(1, 8'h51);
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        chk("l0_gnt", gnt, 4'b0010);
        chk("l0_q", q, 8'h51);
        set_d(1, 8'h52);
        lock = 4'b0000;
        step();
        chk("l1_ack", ack, 4'b0010);
        chk("l1_gnt", gnt, 4'b0000);
        chk("l1_q", q, 8'h52);
        req = 4'b0000;
        step();
        chk("l2_ack", ack, 4'b0000);
        chk("l2_q", q, 8'h52);

        // 6b: reset mid-burst at hold count 2
        set_d(2, 8'h61);
        req  = 4'b0100;
        lock = 4'b0100;
        step();
        chk("r0_gnt", gnt, 4'b0100);
        set_d(2, 8'h62);
        step();
        chk("r1_q", q, 8'h62);
        #2 rst_n = 1'b0;
        #1;
        chk("r_gnt", gnt, 4'b0000);
        chk("r_q", q, 8'h00);
        chk("r_ack", ack, 4'b0000);
        d_in = 32'h13121110;
        req  = 4'b1111;
        lock = 4'b0000;
        #1 rst_n = 1'b1;
        step();
        chk("r_first_ack", ack, 4'b0001);
        chk("r_first_q", q, 8'h10);
        chk("r_first_gnt", gnt, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
